// File: rtl/grid_disp_pkg.sv
// grid_disp_pkg: shared types, sizes and default colours for the grid display scanner
package grid_disp_pkg;
  typedef logic [23:0] rgb_t;
  localparam int GRID_DIM = 8;
  localparam int CELL_IDX_W = 3;
  localparam rgb_t ALIVE_RGB_D = 24'hFFFFFF;
  localparam rgb_t DEAD_RGB_D = 24'h000000;
  localparam rgb_t BORDER_RGB_D = 24'h202020;
  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
endpackage

// File: rtl/grid_display_scanner_raster.sv
// raster_timing_gen: h/v raster counters, registered sync/de decode and frame wrap strobe
// Ports: clk, reset_n (async, active-low), pix_en (pixel tick);
//   h_cnt/v_cnt current raster position, h_nxt/v_nxt position after the next tick,
//   line_end (last pixel of a line), frame_wrap (this clk wraps the raster to (0,0)),
//   hsync/vsync (active-low), de (visible area), all registered one clk after the counters.
module raster_timing_gen
  import grid_disp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int HW = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW = $clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic [HW-1:0] h_nxt,
  output logic [VW-1:0] v_nxt,
  output logic          line_end,
  output logic          frame_wrap,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);
  localparam int HT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  logic frame_end;
  assign line_end = h_cnt == HW'(HT - 1);
  assign frame_end = line_end && v_cnt == VW'(VT - 1);
  assign frame_wrap = pix_en && frame_end;
  assign h_nxt = line_end ? '0 : h_cnt + 1'b1;
  assign v_nxt = frame_end ? '0 : line_end ? v_cnt + 1'b1 : v_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de <= 1'b0;
    end else if (pix_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hsync <= !(h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
      vsync <= !(v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
      de <= h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
    end
endmodule

// File: rtl/grid_display_scanner.sv
// grid_display_scanner: draws the 8x8 Game of Life grid onto a raster with tear-free grid updates
// Ports: clk, reset_n (async, active-low), pix_en (pixel tick), grid_in/grid_valid/grid_ready
//   (grid handshake, accepted only in vertical blanking), frame_start (pulse as raster restarts),
//   hsync/vsync (active-low), de (visible area), rgb {R,G,B} (0 outside visible area).
// Build option: GRID_LINES_EN draws 1-px separators on the first row/column of every cell.
module grid_display_scanner
  import grid_disp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CELL_PX = 60,
  parameter int GRID_X0 = 80,
  parameter int GRID_Y0 = 0,
  parameter rgb_t ALIVE_RGB = ALIVE_RGB_D,
  parameter rgb_t DEAD_RGB = DEAD_RGB_D,
  parameter rgb_t BORDER_RGB = BORDER_RGB_D
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic        grid_ready,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb
);
  localparam int HW = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW = $clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int PW = $clog2(CELL_PX + 1);
  localparam int CW = CELL_IDX_W + 1;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic line_end, frame_wrap, pending, acc, col_last, row_last, vis, in_grid, sep;
  logic [63:0] shadow, disp;
  logic [PW-1:0] col_px, row_px;
  logic [CW-1:0] col_cell, row_cell;
  rgb_t rgb_n;
  raster_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_raster (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .h_nxt(h_nxt), .v_nxt(v_nxt),
    .line_end(line_end), .frame_wrap(frame_wrap),
    .hsync(hsync), .vsync(vsync), .de(de)
  );
  assign grid_ready = v_cnt >= VW'(V_ACTIVE) && !pending;
  assign acc = grid_valid && grid_ready;
  // Cell counters track the current raster position; index GRID_DIM (top bit set) means outside the grid.
  assign col_last = col_px == PW'(CELL_PX - 1);
  assign row_last = row_px == PW'(CELL_PX - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      col_cell <= GRID_X0 == 0 ? '0 : CW'(GRID_DIM);
      row_cell <= GRID_Y0 == 0 ? '0 : CW'(GRID_DIM);
      col_px <= '0;
      row_px <= '0;
    end else if (pix_en) begin
      if (h_nxt == HW'(GRID_X0)) begin
        col_cell <= '0;
        col_px <= '0;
      end else if (!col_cell[CELL_IDX_W]) begin
        col_px <= col_last ? '0 : col_px + 1'b1;
        col_cell <= col_cell + CW'(col_last);
      end
      if (line_end && v_nxt == VW'(GRID_Y0)) begin
        row_cell <= '0;
        row_px <= '0;
      end else if (line_end && !row_cell[CELL_IDX_W]) begin
        row_px <= row_last ? '0 : row_px + 1'b1;
        row_cell <= row_cell + CW'(row_last);
      end
    end
  assign vis = h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
  assign in_grid = !col_cell[CELL_IDX_W] && !row_cell[CELL_IDX_W];
`ifdef GRID_LINES_EN
  assign sep = col_px == '0 || row_px == '0;
`else
  assign sep = 1'b0;
`endif
  assign rgb_n = !vis ? '0 : (!in_grid || sep) ? BORDER_RGB :
                 disp[{row_cell[CELL_IDX_W-1:0], col_cell[CELL_IDX_W-1:0]}] ? ALIVE_RGB : DEAD_RGB;
  // A grid accepted on the wrap clk bypasses the shadow so it shows in the frame starting now.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shadow <= '0;
      disp <= '0;
      pending <= 1'b0;
      frame_start <= 1'b0;
      rgb <= '0;
    end else begin
      frame_start <= frame_wrap;
      if (acc) shadow <= grid_in;
      if (frame_wrap) begin
        disp <= acc ? grid_in : pending ? shadow : disp;
        pending <= 1'b0;
      end else if (acc) pending <= 1'b1;
      if (pix_en) rgb <= rgb_n;
    end
endmodule

// File: tb/tb_grid_display_scanner.sv
// tb_grid_display_scanner: scoreboard bench for grid_display_scanner on a small raster
module tb_grid_display_scanner;
  localparam int HT = 22, VT = 19, FRAME = HT * VT;
  logic clk = 1'b0, reset_n = 1'b0, pix_en = 1'b1, grid_valid = 1'b0;
  logic [63:0] grid_in = '0;
  logic grid_ready, frame_start, hsync, vsync, de;
  logic [23:0] rgb;
  int checks = 0, errors = 0, acc_cnt = 0, fs_cnt = 0, tick = 0, slow = 0, pcnt = 0;
  int mh = 0, mv = 0;
  logic [63:0] mdisp = '0, mshadow = '0;
  logic mpend = 1'b0, exp_fs = 1'b0;
  logic [26:0] last = '0;
  logic [26:0] q[$];
  grid_display_scanner #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CELL_PX(2), .GRID_X0(0), .GRID_Y0(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .grid_in(grid_in),
    .grid_valid(grid_valid), .grid_ready(grid_ready), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    pcnt++;
    pix_en = slow != 0 ? (pcnt % 4 == 0) : 1'b1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv, $time);
    end
  endtask
  function automatic logic [26:0] exp_px(input int h, input int v, input logic [63:0] d);
    logic [23:0] c;
    c = 24'h0;
    if (h < 16 && v < 16) c = d[(v / 2) * 8 + h / 2] ? 24'hFFFFFF : 24'h000000;
`ifdef GRID_LINES_EN
    if (h < 16 && v < 16 && (h % 2 == 0 || v % 2 == 0)) c = 24'h202020;
`endif
    return {!(h >= 18 && h < 20), v != 17, h < 16 && v < 16, c};
  endfunction
  always @(posedge clk) begin : model
    logic a, w;
    if (!reset_n) begin
      mh = 0; mv = 0; mdisp = '0; mshadow = '0; mpend = 1'b0; exp_fs = 1'b0;
      last = {1'b1, 1'b1, 1'b0, 24'h0};
    end else begin
      a = grid_valid === 1'b1 && mv >= 16 && !mpend;
      w = pix_en && mh == HT - 1 && mv == VT - 1;
      if (pix_en) begin
        last = exp_px(mh, mv, mdisp);
        if (mh == HT - 1) begin
          mh = 0;
          mv = mv == VT - 1 ? 0 : mv + 1;
        end else mh++;
      end
      if (a) begin
        mshadow = grid_in;
        acc_cnt++;
      end
      if (w) begin
        mdisp = a ? grid_in : mpend ? mshadow : mdisp;
        mpend = 1'b0;
      end else if (a) mpend = 1'b1;
      exp_fs = w;
    end
    q.push_back(last);
    #1;
    chk("pixel", {hsync, vsync, de, rgb}, q.pop_front());
    chk("frame_start", frame_start, exp_fs);
    chk("grid_ready", grid_ready, mv >= 16 && !mpend);
  end
  always @(posedge clk) begin
    if (!reset_n) tick = 0;
    else if (pix_en) tick++;
    #1;
    if (frame_start) begin
      fs_cnt++;
      chk("frame_period", tick, FRAME);
      tick = 0;
    end
  end
  task automatic wait_frames(input int n);
    int t = fs_cnt + n;
    for (int i = 0; i < n * 2000 && fs_cnt < t; i++) @(negedge clk);
    chk("frame_timeout", fs_cnt >= t, 1);
  endtask
  task automatic wait_accept();
    int n = acc_cnt;
    for (int i = 0; i < 8000 && acc_cnt == n; i++) @(negedge clk);
    chk("accept_timeout", acc_cnt != n, 1);
  endtask
  task automatic offer(input logic [63:0] g);
    grid_in = g;
    grid_valid = 1'b1;
    wait_accept();
    grid_valid = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_ready", grid_ready, 0);
    chk("rst_fs", frame_start, 0);
    reset_n = 1'b1;
    wait_frames(2);
    grid_in = 64'h1;
    grid_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("active_ready", grid_ready, 0);
    wait_accept();
    grid_valid = 1'b0;
    wait_frames(2);
    offer(64'h8000_0000_0000_0000);
    wait_frames(2);
    offer(64'h0123_4567_89AB_CDEF);
    grid_in = 64'hF0F0_0F0F_AA55_55AA;
    grid_valid = 1'b1;
    wait_accept();
    grid_valid = 1'b0;
    wait_frames(2);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (mh == HT - 1 && mv == VT - 1) break;
    end
    grid_in = 64'h00FF_00FF_00FF_00FF;
    grid_valid = 1'b1;
    @(negedge clk);
    grid_valid = 1'b0;
    wait_frames(2);
    offer(64'hDEAD_BEEF_CAFE_F00D);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (mv == 17 && mh == 5) break;
    end
    chk("pre_rst_vsync", vsync, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hsync", hsync, 1);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_de", de, 0);
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_ready", grid_ready, 0);
    chk("mid_rst_fs", frame_start, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_frames(2);
    slow = 1;
    offer('1);
    wait_frames(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
